// File: rtl/alu_pipe_core.sv
// Two-stage pipelined WIDTH-bit ALU with valid/ready flow control, status flags and reserved-opcode error.
// Optional ALU_PIPE_SAT_EN: m_i=0 opcodes 10/11 become signed saturating A+B / A-B.
module alu_pipe_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic [3:0]       opcode_i,
    input  logic             m_i,
    input  logic             cn_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] R_o,
    output logic             co_o,
    output logic             z_o,
    output logic             ov_o,
    output logic             err_o
);

    localparam int MSB = WIDTH - 1;

    logic             s1_v, s2_v;
    logic [WIDTH-1:0] a_q, b_q;
    logic [3:0]       op_q;
    logic             m_q, cn_q;
    logic [WIDTH-1:0] r_q;
    logic             co_q, z_q, ov_q, err_q;

    logic             adv, accept;
    logic [WIDTH:0]   add_x, add_y, add_c, sum;
    logic             ov_add;
    logic [WIDTH-1:0] res;
    logic             co_c, ov_c, err_c;

    assign adv     = !s2_v || ready_i;
    assign ready_o = !rst_i && (!s1_v || !s2_v || ready_i);
    assign accept  = valid_i && ready_o;

    // One shared WIDTH+1 bit adder serves every add/subtract/inc/dec flavour.
    always_comb begin
        add_x = {1'b0, a_q};
        add_y = '0;
        add_c = '0;
        case (op_q)
            4'd0: begin add_y = {1'b0, b_q};  add_c = {{WIDTH{1'b0}}, cn_q}; end
            4'd1: begin add_y = {1'b0, ~b_q}; add_c = {{WIDTH{1'b0}}, cn_q}; end
            4'd2: add_y = {{WIDTH{1'b0}}, 1'b1};
            4'd3: add_y = {1'b0, {WIDTH{1'b1}}};
            4'd9: begin
                add_x = {1'b0, b_q};
                add_y = {1'b0, ~a_q};
                add_c = {{WIDTH{1'b0}}, 1'b1};
            end
`ifdef ALU_PIPE_SAT_EN
            4'd10: add_y = {1'b0, b_q};
            4'd11: begin add_y = {1'b0, ~b_q}; add_c = {{WIDTH{1'b0}}, 1'b1}; end
`endif
            default: add_y = '0;
        endcase
        sum    = add_x + add_y + add_c;
        ov_add = (add_x[MSB] == add_y[MSB]) && (sum[MSB] != add_x[MSB]);
    end

    always_comb begin
        res   = '0;
        co_c  = 1'b0;
        ov_c  = 1'b0;
        err_c = 1'b0;
        if (m_q) begin
            case (op_q)
                4'd0:    res = a_q & b_q;
                4'd1:    res = a_q | b_q;
                4'd2:    res = a_q ^ b_q;
                4'd3:    res = ~a_q;
                4'd4:    res = ~(a_q & b_q);
                4'd5:    res = ~(a_q | b_q);
                4'd6:    res = ~(a_q ^ b_q);
                4'd7:    res = b_q;
                default: res = a_q;
            endcase
        end else begin
            case (op_q)
                4'd0, 4'd1, 4'd2, 4'd3, 4'd9: begin
                    res  = sum[MSB:0];
                    co_c = sum[WIDTH];
                    ov_c = ov_add;
                end
                4'd4: begin res = {a_q[MSB-1:0], cn_q};  co_c = a_q[MSB]; end
                4'd5: begin res = {cn_q, a_q[MSB:1]};    co_c = a_q[0];   end
                4'd6: begin res = {a_q[MSB], a_q[MSB:1]}; co_c = a_q[0];  end
                4'd7: begin res = {a_q[MSB-1:0], a_q[MSB]}; co_c = a_q[MSB]; end
                4'd8: begin res = {a_q[0], a_q[MSB:1]};  co_c = a_q[0];   end
`ifdef ALU_PIPE_SAT_EN
                // Overflow direction follows A's sign for both add and subtract.
                4'd10, 4'd11: begin
                    if (ov_add)
                        res = a_q[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                    else
                        res = sum[MSB:0];
                    co_c = sum[WIDTH];
                    ov_c = ov_add;
                end
`endif
                default: err_c = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_v  <= 1'b0;
            s2_v  <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            m_q   <= 1'b0;
            cn_q  <= 1'b0;
            r_q   <= '0;
            co_q  <= 1'b0;
            z_q   <= 1'b0;
            ov_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (adv) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    r_q   <= res;
                    co_q  <= co_c;
                    z_q   <= (res == '0);
                    ov_q  <= ov_c;
                    err_q <= err_c;
                end
            end
            if (accept) begin
                s1_v <= 1'b1;
                a_q  <= A_i;
                b_q  <= B_i;
                op_q <= opcode_i;
                m_q  <= m_i;
                cn_q <= cn_i;
            end else if (adv) begin
                s1_v <= 1'b0;
            end
        end
    end

    // Outputs are forced quiet while reset is held so no stale beat can transfer.
    assign valid_o = s2_v && !rst_i;
    assign R_o     = rst_i ? '0 : r_q;
    assign co_o    = co_q  && !rst_i;
    assign z_o     = z_q   && !rst_i;
    assign ov_o    = ov_q  && !rst_i;
    assign err_o   = err_q && !rst_i;

endmodule
